keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Input-side companion to the multiplexed 7-segment display. It drives the columns of a 4x4 hex keypad matrix with the same one-cold active-low rotation the display uses for digit select, and senses the rows. It debounces and decodes single key presses into a 4-bit hex code. Each accepted digit is shifted into a 16-bit entry word, so a user can key in a register value and see it on the display.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; must be ≥ 4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames needed to accept a press or a release; must be ≥ 1.
- REPEAT_FRAMES, 32: held frames between auto-repeat pulses; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- row_in  in  4  row sense, active-low (pulled up externally), asynchronous to clk.
- clear  in  1  synchronous clear of entry.
- col_out  out  4  column drive, one-cold active-low.
- key_valid  out  1  one-cycle pulse per accepted key.
- key_code  out  4  code of the last accepted key, held between pulses.
- entry  out  16  last four accepted digits; newest digit in [3:0].

## Operation
- Scan timer:
  - Counts 0..SCAN_DIV-1. The terminal count is the "tick".
  - On each tick, col_out advances 1110→1101→1011→0111→1110.
- Row synchronization:
  - row_in passes through a 2-flop synchronizer.
  - On each tick, the synchronized rows for the current column are latched into a 16-bit frame image.
- Key code mapping:
  - Column index c is the low bit position in col_out; row index r is the low bit position in row_in.
  - code = 4*r + c.
- Frame evaluation: the frame ends on the tick where col_out = 0111. Each frame classifies as:
  - NONE: no key down.
  - SINGLE(k): exactly one key down.
  - MULTI: two or more keys down.
- Debounce FSM, evaluated once per frame end:
  - IDLE:
    - SINGLE(k) → CAND, cnt=1, cand=k.
    - Otherwise stay in IDLE.
  - CAND:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_FRAMES → accept, go to PRESSED.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE, cnt=1. If DEBOUNCE_FRAMES=1, go straight to IDLE instead.
    - SINGLE or MULTI → stay in PRESSED.
  - RELEASE:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_FRAMES → IDLE.
    - Any key → PRESSED. No new accept.
  - DEBOUNCE_FRAMES=1 in IDLE: SINGLE(k) accepts immediately and goes to PRESSED.
- Accept: key_valid=1 for one cycle, key_code=cand, entry={entry[11:0], cand}.
- Clear:
  - clear=1 → entry=0.
  - If an accept happens in the same cycle, entry={12'h000, cand}.
  - clear does not affect the FSM, key_code or scanning.

## Timing
- Reset values: col_out=4'b1110, key_valid=0, key_code=0, entry=0, FSM=IDLE, timer=0, counters=0, synchronizer flops=4'b1111.
- Reset mid-scan or mid-debounce: immediate asynchronous return to the reset values; no partial accept.
- Frame length: 4*SCAN_DIV cycles.
- Accept latency:
  - key_valid, key_code and entry update in the cycle after the frame-end tick that completes the debounce.
  - Earliest accept after a clean press: DEBOUNCE_FRAMES frame ends.
- Row settling: rows are sampled SCAN_DIV-1 cycles after the column change. Together with the 2-cycle synchronizer, this is why SCAN_DIV ≥ 4 is required.
- key_valid is never high in two consecutive cycles.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In PRESSED, while every frame is SINGLE(key_code), a frame counter runs.
  - Every REPEAT_FRAMES frames it issues a further accept with the same code: key_valid pulses and entry shifts.
  - NONE or MULTI resets the repeat counter.
- Undefined: exactly one accept per press; REPEAT_FRAMES is ignored and no repeat counter is synthesized.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=2.
- Reset release, no keys → col_out cycles 1110,1101,1011,0111 every 4 clocks; key_valid stays 0; entry=0.
- Hold key r=2,c=1 (row_in=1011 while col_out=1101) from reset → one key_valid pulse with key_code=9 at the second frame end +1 cycle; entry=16'h0009; no further pulse while held (macro undefined).
- Press and release keys 1, 2, A, F, 3 with ≥3 frames of NONE between them → five pulses; final entry=16'h2AF3.
- Key bounces on for one frame, then off → no key_valid. Keys 0 and 5 held together → no key_valid; FSM stays IDLE.
- entry=16'h1234, clear asserted in the same cycle as the accept of key 7 → entry=16'h0007. Assert rst during CAND → all outputs return to their reset values immediately.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_FRAMES=3, hold key 4 for 12 frames → initial pulse plus a pulse every 3 frames; entry=16'h4444.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 hex keypad: drives one column low at a time, samples the
//   active-low rows, debounces whole-matrix frames and turns each accepted
//   single-key press into a hex digit that is shifted into a 16-bit entry word.
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat while held).
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   row_in     row sense, active-low, asynchronous to clk
//   clear      synchronous clear of entry
//   col_out    column drive, one-cold active-low
//   key_valid  one-cycle pulse per accepted key
//   key_code   code of the last accepted key (4*row + col)
//   entry      last four accepted digits, newest in [3:0]
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_FRAMES   = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   input  logic        clear,
   output logic [3:0]  col_out,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] entry
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

   // Sampling happens SCAN_DIV-1 cycles after a column change; the 2-flop
   // synchronizer needs at least 2 of those cycles for settled rows.
   if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_param_check
      $error("keypad_scanner: SCAN_DIV must be >= 4, frame counts >= 1");
   end

   typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

   logic [TW-1:0] timer;
   logic [1:0]    col_idx;
   logic [3:0]    sync1, sync2;
   logic [15:0]   frame, frame_now;
   logic          tick, frame_end, none, single;
   logic [3:0]    key_k;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    cand, cand_nxt;
   logic          accept;
   logic [3:0]    acc_code;

   assign tick      = (timer == TW'(SCAN_DIV - 1));
   assign frame_end = tick && (col_idx == 2'd3);
   assign col_out   = ~(4'b0001 << col_idx);

   // ---------------- scan timer, column rotation, synchronizer, frame image
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer   <= '0;
         col_idx <= 2'd0;
         sync1   <= 4'hF;
         sync2   <= 4'hF;
         frame   <= '0;
      end else begin
         sync1 <= row_in;
         sync2 <= sync1;
         if (tick) begin
            timer   <= '0;
            col_idx <= col_idx + 2'd1;
            // frame bit index {row, col} equals code 4*r+c; stored active-high
            for (int r = 0; r < 4; r++)
               frame[{r[1:0], col_idx}] <= ~sync2[r];
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   // At frame end the last column is being sampled this very cycle, so
   // classify on the stored image with column 3 replaced by the live sample.
   always_comb begin
      frame_now = frame;
      for (int r = 0; r < 4; r++)
         frame_now[{r[1:0], 2'd3}] = ~sync2[r];
   end

   assign none   = (frame_now == 16'd0);
   assign single = !none && ((frame_now & (frame_now - 16'd1)) == 16'd0);

   always_comb begin
      key_k = 4'd0;
      for (int i = 0; i < 16; i++)
         if (frame_now[i]) key_k = i[3:0];
   end

   // ---------------- debounce FSM
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_FRAMES + 1);
   logic [RW-1:0] rpt, rpt_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt   <= '0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cand  <= cand_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt   <= rpt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      accept    = 1'b0;
      acc_code  = cand;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_nxt   = rpt;
`endif
      if (frame_end) begin
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt_nxt = '0;   // any frame that is not a repeat-qualifying hold restarts
`endif
         case (state)
            IDLE: begin
               if (single) begin
                  cand_nxt = key_k;
                  if (DEBOUNCE_FRAMES == 1) begin
                     accept    = 1'b1;
                     acc_code  = key_k;
                     state_nxt = PRESSED;
                  end else begin
                     cnt_nxt   = CW'(1);
                     state_nxt = CAND;
                  end
               end
            end
            CAND: begin
               if (single && key_k == cand) begin
                  cnt_nxt = cnt + 1'b1;
                  if (cnt_nxt == CW'(DEBOUNCE_FRAMES)) begin
                     accept    = 1'b1;
                     state_nxt = PRESSED;
                  end
               end else if (single) begin
                  cand_nxt = key_k;
                  cnt_nxt  = CW'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end
            PRESSED: begin
               if (none) begin
                  cnt_nxt   = CW'(1);
                  state_nxt = (DEBOUNCE_FRAMES == 1) ? IDLE : RELEASE;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               else if (single && key_k == cand) begin
                  if (rpt == RW'(REPEAT_FRAMES - 1)) accept = 1'b1;
                  else                                rpt_nxt = rpt + 1'b1;
               end
`endif
            end
            RELEASE: begin
               if (none) begin
                  cnt_nxt = cnt + 1'b1;
                  if (cnt_nxt == CW'(DEBOUNCE_FRAMES)) state_nxt = IDLE;
               end else begin
                  state_nxt = PRESSED;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- accept outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         entry     <= 16'd0;
      end else begin
         key_valid <= accept;
         if (accept) begin
            key_code <= acc_code;
            entry    <= clear ? {12'h000, acc_code} : {entry[11:0], acc_code};
         end else if (clear) begin
            entry <= 16'd0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2,
//   REPEAT_FRAMES=3. A behavioural keypad drives row_in from col_out and a
//   16-bit mask of held keys (bit index = 4*row + col). One frame is 16 clocks.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 2;
   localparam int RF = 3;

   logic        clk = 1'b0;
   logic        rst, clear;
   logic [3:0]  row_in, col_out, key_code;
   logic        key_valid;
   logic [15:0] entry;
   logic [15:0] keys;

   int passed = 0, total = 0;
   int pulses = 0, last_pulse_cyc = 0, cyc = 0, consec = 0, start_cyc = 0;
   logic prev_kv = 1'b0;

   typedef struct {
      logic [3:0]  key;
      logic [3:0]  exp_code;
      logic [15:0] exp_entry;
   } vec_t;
   vec_t vt [5];
   logic [3:0] col_seq [4];

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(RF)) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .clear(clear),
      .col_out(col_out), .key_valid(key_valid), .key_code(key_code), .entry(entry)
   );

   always #5 clk = ~clk;

   // keypad matrix: a held key pulls its row low while its column is driven low
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col_out[c] && keys[4*r+c]) row_in[r] = 1'b0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (key_valid) begin
         pulses++;
         last_pulse_cyc = cyc;
         if (prev_kv) consec++;
      end
      prev_kv = key_valid;
   endtask

   task automatic frames(input int n);
      repeat (n * 16) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; keys = 16'h0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0; cyc = 0; prev_kv = 1'b0; pulses = 0;
   endtask

   // key held for 3 frames, released for 3 frames (enough for the release debounce)
   task automatic press(input logic [3:0] k);
      keys = 16'h0001 << k;
      frames(3);
      keys = 16'h0;
      frames(3);
   endtask

   initial begin
      vt[0] = '{4'h1, 4'h1, 16'h0001};
      vt[1] = '{4'h2, 4'h2, 16'h0012};
      vt[2] = '{4'hA, 4'hA, 16'h012A};
      vt[3] = '{4'hF, 4'hF, 16'h12AF};
      vt[4] = '{4'h3, 4'h3, 16'h2AF3};
      col_seq[0] = 4'b1110; col_seq[1] = 4'b1101;
      col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

      // ---- reset state
      rst = 1'b1; clear = 1'b0; keys = 16'h0;
      @(negedge clk); @(negedge clk);
      chk("rst_col_out", 32'(col_out), 32'h0E);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_key_code", 32'(key_code), 32'h0);
      chk("rst_entry", 32'(entry), 32'h0);
      rst = 1'b0; cyc = 0; prev_kv = 1'b0; pulses = 0;

      // ---- column rotation with no keys
      for (int n = 1; n <= 16; n++) begin
         step();
         chk($sformatf("col_out_cyc%0d", n), 32'(col_out), 32'(col_seq[(n/4)%4]));
      end
      chk("idle_no_pulse", 32'(pulses), 32'h0);
      chk("idle_entry", 32'(entry), 32'h0);

      // ---- key 9 (row 2, col 1) held from reset
      do_reset();
      keys = 16'h0001 << 9;
      frames(2);
      chk("k9_pulses", 32'(pulses), 32'd1);
      chk("k9_pulse_cycle", 32'(last_pulse_cyc), 32'd32);
      chk("k9_code", 32'(key_code), 32'h9);
      chk("k9_entry", 32'(entry), 32'h0009);
      frames(4);
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("k9_held_pulses", 32'(pulses), 32'd2);
`else
      chk("k9_held_pulses", 32'(pulses), 32'd1);
`endif
      keys = 16'h0;
      frames(3);

      // ---- table of key presses
      do_reset();
      for (int i = 0; i < 5; i++) begin
         pulses = 0;
         press(vt[i].key);
         chk($sformatf("tbl%0d_pulses", i), 32'(pulses), 32'd1);
         chk($sformatf("tbl%0d_code", i), 32'(key_code), 32'(vt[i].exp_code));
         chk($sformatf("tbl%0d_entry", i), 32'(entry), 32'(vt[i].exp_entry));
      end

      // ---- one-frame bounce, then two keys together
      pulses = 0;
      keys = 16'h0001 << 6;
      frames(1);
      keys = 16'h0;
      frames(3);
      chk("bounce_no_pulse", 32'(pulses), 32'd0);
      keys = 16'h0021;
      frames(4);
      keys = 16'h0;
      frames(3);
      chk("multi_no_pulse", 32'(pulses), 32'd0);
      chk("multi_entry_kept", 32'(entry), 32'h2AF3);
      // FSM must be back in IDLE: a clean press accepts exactly two frames later
      start_cyc = cyc;
      keys = 16'h0001 << 5;
      frames(2);
      chk("after_multi_pulses", 32'(pulses), 32'd1);
      chk("after_multi_latency", 32'(last_pulse_cyc - start_cyc), 32'd32);
      keys = 16'h0;
      frames(3);
      chk("after_multi_entry", 32'(entry), 32'hAF35);

      // ---- clear coincident with accept
      do_reset();
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      chk("pre_clear_entry", 32'(entry), 32'h1234);
      pulses = 0;
      keys = 16'h0001 << 7;
      repeat (31) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_acc_pulses", 32'(pulses), 32'd1);
      chk("clr_acc_entry", 32'(entry), 32'h0007);
      chk("clr_acc_code", 32'(key_code), 32'h7);
      step();
      chk("clr_acc_entry_hold", 32'(entry), 32'h0007);
      keys = 16'h0;
      frames(3);

      // ---- reset while in CAND
      pulses = 0;
      keys = 16'h0001 << 12;
      frames(1);
      repeat (5) step();
      rst = 1'b1;
      #1;
      chk("mid_rst_col_out", 32'(col_out), 32'h0E);
      chk("mid_rst_key_valid", 32'(key_valid), 32'h0);
      chk("mid_rst_key_code", 32'(key_code), 32'h0);
      chk("mid_rst_entry", 32'(entry), 32'h0);
      @(negedge clk);
      rst = 1'b0; cyc = 0; prev_kv = 1'b0;
      frames(1);
      chk("mid_rst_no_partial", 32'(pulses), 32'd0);
      frames(1);
      chk("mid_rst_fresh_accept", 32'(pulses), 32'd1);
      chk("mid_rst_fresh_code", 32'(key_code), 32'hC);
      keys = 16'h0;
      frames(3);

      // ---- long hold of key 4
      do_reset();
      keys = 16'h0001 << 4;
      frames(12);
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("hold4_pulses", 32'(pulses), 32'd4);
      chk("hold4_entry", 32'(entry), 32'h4444);
`else
      chk("hold4_pulses", 32'(pulses), 32'd1);
      chk("hold4_entry", 32'(entry), 32'h0004);
`endif
      keys = 16'h0;
      frames(3);

      chk("no_back_to_back_valid", 32'(consec), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
